iq_issue_sched: RTL and testbench
=================================

// Module: iq_issue_sched
// PURPOSE
//  Dual-issue scheduler that sits between the instruction queue and the ID/EX register.
//  It looks at the two head entries of the queue plus their decode info, and decides each
//  cycle how many entries to dequeue and issue: none, slot0 only, or both.
//  Its ID_upDateMode_o output drives the queue's ID_upDateMode_i dequeue control.
//  It enforces three rules: intra-pair RAW, branch/delay-slot pairing and privileged
//  serialization. It also tracks occupancy of the non-pipelined mul/div unit.
// PARAMETERS
//  MD_LAT   4                    cycles the mul/div unit stays busy after accepting an op (>=1)
//  CNT_W    $clog2(MD_LAT+1)     width of the mul/div busy counter
// PORTS
//  clk                 in   1    core clock
//  rst                 in   1    asynchronous reset, active-high
//  SBA_flush_w_i       in   1    branch-mispredict flush
//  CP0_excOccur_w_i    in   1    exception flush
//  IQ_supplyValid_i    in   2    head-entry valid: 2'b00, 2'b01 or 2'b11 only
//  DC_wrEn_p_i         in   2    slot[i] writes a GPR
//  DC_wrReg_p_i        in   10   slot[i] destination, 5b each
//  DC_rdEn_p_i         in   4    {slot1 rt,rs, slot0 rt,rs} read enables
//  DC_rdReg_p_i        in   20   matching source regs, 5b each
//  DC_isBranch_p_i     in   2    slot[i] is a branch/jump (owns a delay slot)
//  DC_isPriv_p_i       in   2    slot[i] is CP0/ERET/SYSCALL/BREAK-class (serializing)
//  DC_isMulDiv_p_i     in   2    slot[i] uses the mul/div unit
//  EX_stall_i          in   1    ID/EX register cannot accept this cycle
//  BE_empty_i          in   1    no instruction in flight past ID
//  ID_upDateMode_o     out  2    combinational dequeue count: 2'b00, 2'b01 or 2'b11
//  ID_issueValid_o     out  2    combinational issue mask to ID/EX; equals ID_upDateMode_o
//  ID_state_o          out  2    FSM state: 0 RUN, 1 WAIT_DS, 2 DRAIN
//  ID_mdBusy_o         out  1    mul/div busy counter != 0
// BEHAVIOUR
//  Reset (async, rst=1): state RUN, mdCnt=0. All outputs read 0 during reset.
//  Stall condition: issue = 2'b00 when any of the following holds:
//   - needClear = SBA_flush_w_i | CP0_excOccur_w_i
//   - EX_stall_i
//   - IQ_supplyValid_i == 2'b00
//  Otherwise the slot0 rules below are evaluated in priority order, first match wins:
//   1 slot0 priv & !BE_empty_i -> 00, next state DRAIN.
//     slot0 priv & BE_empty_i -> 01; a priv op never dual-issues.
//   2 slot0 mul/div & mdBusy -> 00.
//   3 slot0 branch & supply==01 -> 00, next state WAIT_DS.
//     slot0 branch & supply==11 -> 11; branch+DS always pair, with no RAW check.
//   4 supply==01 -> 01.
//   5 Slot1 blockers give 01 (slot1 stays queued). Any of:
//     - slot1 branch
//     - slot1 priv
//     - slot1 mul/div & (slot0 mul/div | mdBusy)
//     - RAW: slot1 rdEn & rdReg == slot0 wrReg, slot0 wrEn, wrReg != 0
//     - WAW: both wrEn, equal non-zero wrReg
//   6 else -> 11.
//  FSM (registered, advances on posedge):
//   - RUN -> WAIT_DS or DRAIN per rules 1/3 above.
//   - WAIT_DS -> RUN when the pair issues; -> RUN on needClear.
//   - DRAIN -> RUN when the priv op issues; -> RUN on needClear.
//   - State only reports status; issue is always re-derived from the current inputs.
//  needClear has priority over all other transitions: forces RUN and issue 00 the same cycle.
//  mdCnt:
//   - If a mul/div issues in either slot: load MD_LAT-1 (MD_LAT=1 gives no busy).
//   - Else if mdCnt != 0: decrement.
//   - Flush does not clear mdCnt; the unit cannot abort.
//   - Saturates at 0; never wraps.
//  Register 0 never creates a hazard. Reg compares are 5b equality.
//  Output encodings 2'b10 and state 3 are illegal; add an assertion on both.
// TESTING
//  T1 supply=11, slot0 add r3, slot1 reads r3 -> mode 01; next cycle new pair, no hazard -> 11.
//  T2 slot0 beq, supply=01 for 3 cycles -> mode 00, state WAIT_DS;
//     then supply=11 -> mode 11, state RUN.
//  T3 slot0 mtc0, BE_empty_i=0 for 2 cycles -> 00/DRAIN; BE_empty_i=1 -> 01, never 11.
//  T4 MD_LAT=4: mult issues in slot0 at cycle t; div at slot0 from t+1 -> 00 at t+1..t+3;
//     the div issues at t+4.
//  T5 CP0_excOccur_w_i in WAIT_DS with EX_stall_i=1 -> mode 00, state RUN next cycle;
//     mdCnt keeps counting down.
//  T6 assert rst mid-DRAIN with mdCnt=2 -> outputs 0 immediately, no clock edge needed;
//     after release state RUN, mdBusy 0.

Source files
------------

// File: rtl/iq_issue_sched_if.sv
// Bundle between the instruction queue / decode side and the dual-issue
// scheduler. The queue/decode side drives the *_i signals and consumes the
// *_o signals; the scheduler is the opposite end.
//
// Dequeue handshake: each cycle ID_upDateMode_o is a combinational count of
// head entries taken this cycle (2'b00 none, 2'b01 slot0, 2'b11 both). An entry
// counts as dequeued and issued only if its supply bit is set and the same bit
// of ID_upDateMode_o is set at the rising clock edge. The queue must keep
// offering a valid entry until that happens, and it never presents a lone
// slot1.
interface iq_issue_sched_if;
  logic        SBA_flush_w_i;
  logic        CP0_excOccur_w_i;
  logic [1:0]  IQ_supplyValid_i;
  logic [1:0]  DC_wrEn_p_i;
  logic [9:0]  DC_wrReg_p_i;
  logic [3:0]  DC_rdEn_p_i;
  logic [19:0] DC_rdReg_p_i;
  logic [1:0]  DC_isBranch_p_i;
  logic [1:0]  DC_isPriv_p_i;
  logic [1:0]  DC_isMulDiv_p_i;
  logic        EX_stall_i;
  logic        BE_empty_i;
  logic [1:0]  ID_upDateMode_o;
  logic [1:0]  ID_issueValid_o;
  logic [1:0]  ID_state_o;
  logic        ID_mdBusy_o;

  modport master (
    output SBA_flush_w_i, CP0_excOccur_w_i, IQ_supplyValid_i,
    output DC_wrEn_p_i, DC_wrReg_p_i, DC_rdEn_p_i, DC_rdReg_p_i,
    output DC_isBranch_p_i, DC_isPriv_p_i, DC_isMulDiv_p_i,
    output EX_stall_i, BE_empty_i,
    input  ID_upDateMode_o, ID_issueValid_o, ID_state_o, ID_mdBusy_o
  );

  modport slave (
    input  SBA_flush_w_i, CP0_excOccur_w_i, IQ_supplyValid_i,
    input  DC_wrEn_p_i, DC_wrReg_p_i, DC_rdEn_p_i, DC_rdReg_p_i,
    input  DC_isBranch_p_i, DC_isPriv_p_i, DC_isMulDiv_p_i,
    input  EX_stall_i, BE_empty_i,
    output ID_upDateMode_o, ID_issueValid_o, ID_state_o, ID_mdBusy_o
  );
endinterface

// File: rtl/iq_issue_sched.sv
// Dual-issue scheduler between the instruction queue and the ID/EX register.
// Each cycle it decides whether to issue nothing, slot0 only, or both head
// entries. It enforces intra-pair RAW/WAW, branch + delay-slot pairing and
// privileged-op serialization, and it tracks the non-pipelined mul/div unit.
// The FSM state is informational only: issue is always derived from the
// current inputs.
module iq_issue_sched #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input logic             clk,
  input logic             rst,
  iq_issue_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_DS = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic [1:0] issue;
  logic       rule_drain;
  logic       rule_wait;
  logic       need_clear;
  logic       stall;
  logic       md_busy;
  logic       two_valid;
  logic [4:0] wr0, wr1, rs1, rt1;
  logic       raw_hit, waw_hit, slot1_block, md_issue;

  // Slot0 read operands never matter: only slot1 can depend on slot0.
  logic unused_slot0_reads;
  assign unused_slot0_reads = ^{bus.DC_rdEn_p_i[1:0], bus.DC_rdReg_p_i[9:0]};

  assign wr0 = bus.DC_wrReg_p_i[4:0];
  assign wr1 = bus.DC_wrReg_p_i[9:5];
  assign rs1 = bus.DC_rdReg_p_i[14:10];
  assign rt1 = bus.DC_rdReg_p_i[19:15];

  assign need_clear = bus.SBA_flush_w_i | bus.CP0_excOccur_w_i;
  assign stall      = need_clear | bus.EX_stall_i | (bus.IQ_supplyValid_i == 2'b00);
  assign two_valid  = bus.IQ_supplyValid_i[1];
  assign md_busy    = (md_cnt_q != '0);

  // Register 0 is hard-wired, so writes to it never create a dependency.
  assign raw_hit = bus.DC_wrEn_p_i[0] && (wr0 != 5'd0) &&
                   ((bus.DC_rdEn_p_i[2] && (rs1 == wr0)) ||
                    (bus.DC_rdEn_p_i[3] && (rt1 == wr0)));
  assign waw_hit = (bus.DC_wrEn_p_i == 2'b11) && (wr0 != 5'd0) && (wr0 == wr1);

  assign slot1_block = bus.DC_isBranch_p_i[1] | bus.DC_isPriv_p_i[1] |
                       (bus.DC_isMulDiv_p_i[1] & (bus.DC_isMulDiv_p_i[0] | md_busy)) |
                       raw_hit | waw_hit;

  // Issue decision: stalls first, then slot0 rules in priority order.
  always_comb begin
    issue      = 2'b00;
    rule_drain = 1'b0;
    rule_wait  = 1'b0;
    if (stall) begin
      issue = 2'b00;
    end else if (bus.DC_isPriv_p_i[0]) begin
      // Serializing op waits for the back end to empty and always issues alone.
      if (bus.BE_empty_i) issue = 2'b01;
      else                rule_drain = 1'b1;
    end else if (bus.DC_isMulDiv_p_i[0] && md_busy) begin
      issue = 2'b00;
    end else if (bus.DC_isBranch_p_i[0]) begin
      // A branch only leaves together with its delay slot; no RAW check inside the pair.
      if (two_valid) issue = 2'b11;
      else           rule_wait = 1'b1;
    end else if (!two_valid) begin
      issue = 2'b01;
    end else if (slot1_block) begin
      issue = 2'b01;
    end else begin
      issue = 2'b11;
    end
  end

  assign md_issue = (issue[0] & bus.DC_isMulDiv_p_i[0]) |
                    (issue[1] & bus.DC_isMulDiv_p_i[1]);

  // FSM next state; a flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (need_clear) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (rule_drain)     state_d = DRAIN;
          else if (rule_wait) state_d = WAIT_DS;
        end
        WAIT_DS: if (issue == 2'b11)  state_d = RUN;
        DRAIN:   if (issue != 2'b00)  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Mul/div busy counter: reload on issue, otherwise count down to zero.
  // Flushes do not touch it because the unit cannot abort an op.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue)     md_cnt_d = MD_LOAD;
    else if (md_busy) md_cnt_d = md_cnt_q - CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Issue outputs are forced low while reset is held, since they are combinational.
  assign bus.ID_upDateMode_o = rst ? 2'b00 : issue;
  assign bus.ID_issueValid_o = rst ? 2'b00 : issue;
  assign bus.ID_state_o      = state_q;
  assign bus.ID_mdBusy_o     = md_busy;

  a_mode_legal: assert property (@(posedge clk) disable iff (rst)
    bus.ID_upDateMode_o != 2'b10);
  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    state_q != 2'b11);

endmodule

// File: tb/tb_iq_issue_sched.sv
// Bench for iq_issue_sched: one task per scenario, each driving a short
// stimulus table, pushing the expected {mode, issue, state, busy} word into a
// scoreboard queue and popping/comparing it against the DUT the same cycle.
module tb_iq_issue_sched;

  logic clk;
  logic rst;
  iq_issue_sched_if ifc ();

  iq_issue_sched #(.MD_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic       flush;
    logic       exc;
    logic       stall;
    logic       be;
    logic [1:0] sup;
    logic [1:0] wen;
    logic [4:0] w0;
    logic [4:0] w1;
    logic [3:0] ren;
    logic [4:0] rs1;
    logic [4:0] rt1;
    logic [1:0] br;
    logic [1:0] priv;
    logic [1:0] md;
    logic [6:0] exp;
  } stim_t;

  logic [6:0] exp_q[$];
  int n_tests;
  int n_fail;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ex(input logic [1:0] m, input logic [1:0] s, input logic b);
    return {m, m, s, b};
  endfunction

  function automatic stim_t st(input logic [1:0] sup, input logic [1:0] wen,
                               input logic [4:0] w0, input logic [4:0] w1,
                               input logic [3:0] ren, input logic [4:0] rs1,
                               input logic [4:0] rt1, input logic [6:0] e);
    stim_t s;
    s = '0;
    s.be = 1'b1; s.sup = sup; s.wen = wen; s.w0 = w0; s.w1 = w1;
    s.ren = ren; s.rs1 = rs1; s.rt1 = rt1; s.exp = e;
    return s;
  endfunction

  function automatic logic [6:0] sample();
    return {ifc.ID_upDateMode_o, ifc.ID_issueValid_o, ifc.ID_state_o, ifc.ID_mdBusy_o};
  endfunction

  // driver
  task automatic drive(input stim_t s);
    ifc.SBA_flush_w_i    = s.flush;
    ifc.CP0_excOccur_w_i = s.exc;
    ifc.EX_stall_i       = s.stall;
    ifc.BE_empty_i       = s.be;
    ifc.IQ_supplyValid_i = s.sup;
    ifc.DC_wrEn_p_i      = s.wen;
    ifc.DC_wrReg_p_i     = {s.w1, s.w0};
    ifc.DC_rdEn_p_i      = s.ren;
    ifc.DC_rdReg_p_i     = {s.rt1, s.rs1, 5'd30, 5'd29};
    ifc.DC_isBranch_p_i  = s.br;
    ifc.DC_isPriv_p_i    = s.priv;
    ifc.DC_isMulDiv_p_i  = s.md;
  endtask

  task automatic test_reset();
    logic [6:0] e, g;
    stim_t s;
    rst = 1'b1;
    s = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    drive(s);
    #3;
    exp_q.push_back(s.exp);
    n_tests++; e = exp_q.pop_front(); g = sample();
    if (g !== e) begin n_fail++; $display("FAIL reset_hold got=%b required=%b", g, e); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s.exp = ex(2'b11, 2'd0, 1'b0);
    drive(s);
    exp_q.push_back(s.exp);
    #2;
    n_tests++; e = exp_q.pop_front(); g = sample();
    if (g !== e) begin n_fail++; $display("FAIL reset_release got=%b required=%b", g, e); end
  endtask

  task automatic test_hazards();
    stim_t v[13];
    logic [6:0] e, g;
    v[0]  = st(2'b11, 2'b01, 5'd3, 5'd0, 4'b0100, 5'd3, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[1]  = st(2'b11, 2'b01, 5'd4, 5'd0, 4'b0100, 5'd5, 5'd0, ex(2'b11, 2'd0, 1'b0));
    v[2]  = st(2'b11, 2'b01, 5'd0, 5'd0, 4'b1100, 5'd0, 5'd0, ex(2'b11, 2'd0, 1'b0));
    v[3]  = st(2'b11, 2'b11, 5'd7, 5'd7, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[4]  = st(2'b11, 2'b11, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b11, 2'd0, 1'b0));
    v[5]  = st(2'b11, 2'b01, 5'd9, 5'd0, 4'b1000, 5'd1, 5'd9, ex(2'b01, 2'd0, 1'b0));
    v[6]  = st(2'b11, 2'b00, 5'd9, 5'd0, 4'b1000, 5'd1, 5'd9, ex(2'b11, 2'd0, 1'b0));
    v[7]  = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[7].br = 2'b10;
    v[8]  = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[8].priv = 2'b10;
    v[9]  = st(2'b01, 2'b01, 5'd3, 5'd0, 4'b0100, 5'd3, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[10] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[10].stall = 1'b1;
    v[11] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[12] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[12].flush = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL hazards[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [6:0] e, g;
    logic [1:0] m;
    logic haz;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 3);
      s = st(2'b00, 2'(($urandom_range(0, 3))), 5'($urandom_range(0, 5)),
             5'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
             5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 7'd0);
      s.sup   = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      s.stall = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 11) == 0);
      haz = (s.wen[0] && s.w0 != 5'd0 &&
             ((s.ren[2] && s.rs1 == s.w0) || (s.ren[3] && s.rt1 == s.w0))) ||
            (s.wen == 2'b11 && s.w0 != 5'd0 && s.w0 == s.w1);
      if (s.stall || s.flush || s.sup == 2'b00) m = 2'b00;
      else if (s.sup == 2'b01)                  m = 2'b01;
      else if (haz)                             m = 2'b01;
      else                                      m = 2'b11;
      s.exp = ex(m, 2'd0, 1'b0);
      @(negedge clk);
      drive(s);
      exp_q.push_back(s.exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL random[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_branch_ds();
    stim_t v[9];
    logic [6:0] e, g;
    v[0] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[1] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd1, 1'b0));
    v[2] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd1, 1'b0));
    v[3] = st(2'b11, 2'b01, 5'd5, 5'd0, 4'b0100, 5'd5, 5'd0, ex(2'b11, 2'd1, 1'b0));
    v[4] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[5] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[6] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd1, 1'b0));
    v[6].stall = 1'b1;
    v[7] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b11, 2'd1, 1'b0));
    v[8] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    for (int i = 0; i < 8; i++) v[i].br = 2'b01;
    v[4].br = 2'b00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL branch_ds[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_priv_drain();
    stim_t v[6];
    logic [6:0] e, g;
    v[0] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[1] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd2, 1'b0));
    v[2] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd2, 1'b0));
    v[3] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[4] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[5] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[0].priv = 2'b01; v[0].be = 1'b0;
    v[1].priv = 2'b01; v[1].be = 1'b0;
    v[2].priv = 2'b01;
    v[4].priv = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL priv_drain[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_muldiv();
    stim_t v[19];
    logic [6:0] e, g;
    logic [1:0] mode_t[19] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00,
                               2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00,
                               2'b00, 2'b00, 2'b00};
    logic       busy_t[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 19; i++)
      v[i] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(mode_t[i], 2'd0, busy_t[i]));
    for (int i = 0; i < 5; i++) begin v[i].sup = 2'b01; v[i].md = 2'b01; end
    v[5].sup = 2'b11;  v[5].md = 2'b10;
    v[9].sup = 2'b11;  v[9].md = 2'b11;
    v[14].sup = 2'b11; v[14].md = 2'b10;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL muldiv[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_flush();
    stim_t v[8];
    logic [6:0] e, g;
    v[0] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b11, 2'd0, 1'b0));
    v[0].md = 2'b01;
    v[1] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b1));
    v[1].br = 2'b01;
    v[2] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd1, 1'b1));
    v[2].br = 2'b01; v[2].exc = 1'b1; v[2].stall = 1'b1;
    v[3] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b1));
    v[4] = st(2'b11, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[4].flush = 1'b1;
    v[5] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    v[5].priv = 2'b01; v[5].be = 1'b0;
    v[6] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd2, 1'b0));
    v[6].priv = 2'b01; v[6].be = 1'b0; v[6].flush = 1'b1;
    v[7] = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL flush[%0d] got=%b required=%b", i, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t v[2];
    stim_t s;
    logic [6:0] e, g;
    v[0] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b01, 2'd0, 1'b0));
    v[0].md = 2'b01;
    v[1] = st(2'b01, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b1));
    v[1].priv = 2'b01; v[1].be = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(v[i]);
      exp_q.push_back(v[i].exp);
      #2;
      n_tests++; e = exp_q.pop_front(); g = sample();
      if (g !== e) begin n_fail++; $display("FAIL reset_mid_setup[%0d] got=%b required=%b", i, g, e); end
    end
    // Now in DRAIN with two busy cycles left; the priv op would issue if not for reset.
    @(negedge clk);
    s = v[1];
    s.be = 1'b1;
    s.exp = ex(2'b01, 2'd2, 1'b1);
    drive(s);
    exp_q.push_back(s.exp);
    #1;
    n_tests++; e = exp_q.pop_front(); g = sample();
    if (g !== e) begin n_fail++; $display("FAIL reset_mid_before got=%b required=%b", g, e); end
    rst = 1'b1;
    exp_q.push_back(ex(2'b00, 2'd0, 1'b0));
    #1;
    n_tests++; e = exp_q.pop_front(); g = sample();
    if (g !== e) begin n_fail++; $display("FAIL reset_mid_async got=%b required=%b", g, e); end
    @(negedge clk);
    rst = 1'b0;
    s = st(2'b00, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0, 5'd0, ex(2'b00, 2'd0, 1'b0));
    drive(s);
    exp_q.push_back(s.exp);
    #2;
    n_tests++; e = exp_q.pop_front(); g = sample();
    if (g !== e) begin n_fail++; $display("FAIL reset_mid_after got=%b required=%b", g, e); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_hazards();
    test_random();
    test_branch_ds();
    test_priv_drain();
    test_muldiv();
    test_flush();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
